// File: rtl/tx_link_ctrl_multilane.sv
// Multi-lane JESD204B transmit link controller: SYNC~-driven CGS/ILAS/DATA sequencing,
// free-running LMFC counter, per-lane ILA generation. Optional test pattern: TX_LINK_TEST_PATTERN_EN.
module tx_link_ctrl_multilane #(
    parameter int         LANES  = 2,
    parameter int         F      = 2,
    parameter int         K      = 16,
    parameter int         ILA_MF = 4,
    parameter logic [7:0] DID    = 8'h0C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sync_n,
    input  logic [8*LANES-1:0]   i_data,
    input  logic [LANES-1:0]     i_k,
    input  logic                 i_vld,
`ifdef TX_LINK_TEST_PATTERN_EN
    input  logic                 i_test_en,
`endif
    output logic [8*LANES-1:0]   o_data,
    output logic [LANES-1:0]     o_k,
    output logic                 o_vld,
    output logic                 o_ready,
    output logic                 o_lmfc_pulse,
    output logic [1:0]           o_state,
    output logic                 o_sync_err
);

    localparam int         FK       = F * K;
    localparam logic [7:0] LAST_OCT = 8'(FK - 1);
    localparam logic [7:0] LAST_MF  = 8'(ILA_MF - 1);

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   lmfc_q, lmfc_d;
    logic [7:0]   mf_q, mf_d;
    logic [1:0]   low_q, low_d;
    logic         lmfc_wrap;

    logic [8*LANES-1:0] o_data_q, o_data_d;
    logic [LANES-1:0]   o_k_q, o_k_d;
    logic               o_vld_q, o_vld_d;
    logic               o_ready_q, o_ready_d;
    logic               o_lmfc_pulse_q, o_lmfc_pulse_d;
    logic [1:0]         o_state_q, o_state_d;
    logic               o_sync_err_q, o_sync_err_d;

`ifdef TX_LINK_TEST_PATTERN_EN
    logic [3:0] tp_q, tp_d;
    logic       test_active;
    assign test_active = i_test_en;
    assign tp_d        = (state_q == ST_DATA) ? tp_q + 4'd1 : 4'd0;
`endif

    // Returns {k, octet} for one lane of the ILA sequence.
    function automatic logic [8:0] ila_octet(input logic [7:0] lane,
                                             input logic [7:0] mf,
                                             input logic [7:0] oct);
        logic [8:0] res;
        res = {1'b0, oct};
        if (oct == 8'd0) begin
            res = {1'b1, 8'h1C};
        end else if (oct == LAST_OCT) begin
            res = {1'b1, 8'h7C};
        end else if (mf == 8'd1) begin
            case (oct)
                8'd1:    res = {1'b1, 8'h9C};
                8'd2:    res = {1'b0, DID};
                8'd3:    res = {1'b0, lane};
                8'd4:    res = {1'b0, 8'(LANES - 1)};
                8'd5:    res = {1'b0, 8'(F - 1)};
                8'd6:    res = {1'b0, 8'(K - 1)};
                default: res = {1'b0, oct};
            endcase
        end
        return res;
    endfunction

    assign lmfc_wrap = (lmfc_q == LAST_OCT);

    always_comb begin
        lmfc_d       = lmfc_wrap ? 8'd0 : lmfc_q + 8'd1;
        state_d      = state_q;
        mf_d         = mf_q;
        low_d        = low_q;
        o_sync_err_d = 1'b0;
        case (state_q)
            ST_ILAS, ST_DATA: begin
                if (state_q == ST_ILAS && lmfc_wrap) begin
                    mf_d = mf_q + 8'd1;
                    if (mf_q == LAST_MF) begin
                        state_d = ST_DATA;
                    end
                end
                // Resync is evaluated last so it overrides the ILAS->DATA step on the same wrap.
                if (!i_sync_n) begin
                    if (low_q == 2'd3) begin
                        state_d = ST_CGS;
                        low_d   = 2'd0;
                        mf_d    = 8'd0;
                    end else begin
                        low_d = low_q + 2'd1;
                    end
                end else begin
                    low_d        = 2'd0;
                    o_sync_err_d = (low_q != 2'd0);
                end
            end
            default: begin
                state_d = ST_CGS;
                low_d   = 2'd0;
                mf_d    = 8'd0;
                if (i_sync_n && lmfc_wrap) begin
                    state_d = ST_ILAS;
                end
            end
        endcase
    end

    always_comb begin
        o_vld_d = 1'b0;
        case (state_q)
            ST_CGS, ST_ILAS: o_vld_d = 1'b1;
            ST_DATA: begin
`ifdef TX_LINK_TEST_PATTERN_EN
                o_vld_d = test_active ? 1'b1 : i_vld;
`else
                o_vld_d = i_vld;
`endif
            end
            default: o_vld_d = 1'b0;
        endcase
    end

    assign o_ready_d      = (state_q == ST_DATA);
    assign o_lmfc_pulse_d = (lmfc_q == 8'd0);
    assign o_state_d      = state_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [8:0] ila_w;
        logic [7:0] oct_d;
        logic       k_d;

        assign ila_w = ila_octet(8'(gi), mf_q, lmfc_q);

        always_comb begin
            oct_d = 8'h00;
            k_d   = 1'b0;
            case (state_q)
                ST_CGS: begin
                    oct_d = 8'hBC;
                    k_d   = 1'b1;
                end
                ST_ILAS: begin
                    oct_d = ila_w[7:0];
                    k_d   = ila_w[8];
                end
                ST_DATA: begin
`ifdef TX_LINK_TEST_PATTERN_EN
                    if (test_active) begin
                        oct_d = {4'(gi), tp_q};
                    end else
`endif
                    if (i_vld) begin
                        oct_d = i_data[8*gi +: 8];
                        k_d   = i_k[gi];
                    end
                end
                default: begin
                    oct_d = 8'h00;
                    k_d   = 1'b0;
                end
            endcase
        end

        assign o_data_d[8*gi +: 8] = oct_d;
        assign o_k_d[gi]           = k_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_CGS;
            lmfc_q         <= 8'd0;
            mf_q           <= 8'd0;
            low_q          <= 2'd0;
            o_data_q       <= '0;
            o_k_q          <= '0;
            o_vld_q        <= 1'b0;
            o_ready_q      <= 1'b0;
            o_lmfc_pulse_q <= 1'b0;
            o_state_q      <= 2'd0;
            o_sync_err_q   <= 1'b0;
`ifdef TX_LINK_TEST_PATTERN_EN
            tp_q           <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            lmfc_q         <= lmfc_d;
            mf_q           <= mf_d;
            low_q          <= low_d;
            o_data_q       <= o_data_d;
            o_k_q          <= o_k_d;
            o_vld_q        <= o_vld_d;
            o_ready_q      <= o_ready_d;
            o_lmfc_pulse_q <= o_lmfc_pulse_d;
            o_state_q      <= o_state_d;
            o_sync_err_q   <= o_sync_err_d;
`ifdef TX_LINK_TEST_PATTERN_EN
            tp_q           <= tp_d;
`endif
        end
    end

    assign o_data       = o_data_q;
    assign o_k          = o_k_q;
    assign o_vld        = o_vld_q;
    assign o_ready      = o_ready_q;
    assign o_lmfc_pulse = o_lmfc_pulse_q;
    assign o_state      = o_state_q;
    assign o_sync_err   = o_sync_err_q;

endmodule

// File: tb/tb_tx_link_ctrl_multilane.sv
// Scoreboard bench for tx_link_ctrl_multilane (LANES=2, F=2, K=4, ILA_MF=4).
// Stimulus pushes the hand-derived expected output per edge; a monitor pops and compares on negedge.
module tb_tx_link_ctrl_multilane;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sync_n = 1'b0;
    logic [15:0] i_data = 16'h0000;
    logic [1:0]  i_k = 2'b00;
    logic        i_vld = 1'b0;
`ifdef TX_LINK_TEST_PATTERN_EN
    logic        i_test_en = 1'b0;
`endif
    logic [15:0] o_data;
    logic [1:0]  o_k;
    logic        o_vld;
    logic        o_ready;
    logic        o_lmfc_pulse;
    logic [1:0]  o_state;
    logic        o_sync_err;

    always #5 clk = ~clk;

    tx_link_ctrl_multilane #(
        .LANES (2),
        .F     (2),
        .K     (4),
        .ILA_MF(4),
        .DID   (8'h0C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sync_n    (i_sync_n),
        .i_data      (i_data),
        .i_k         (i_k),
        .i_vld       (i_vld),
`ifdef TX_LINK_TEST_PATTERN_EN
        .i_test_en   (i_test_en),
`endif
        .o_data      (o_data),
        .o_k         (o_k),
        .o_vld       (o_vld),
        .o_ready     (o_ready),
        .o_lmfc_pulse(o_lmfc_pulse),
        .o_state     (o_state),
        .o_sync_err  (o_sync_err)
    );

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [1:0]  k;
        logic        vld;
        logic        rdy;
        logic        pulse;
        logic        err;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   j = 0;    // edges since reset release; output octet index is j%8

    // Hand-written ILA tables (DID=0C, LANES-1=1, F-1=1, K-1=3).
    logic [7:0] ila_mf1_l0 [8] = '{8'h1C, 8'h9C, 8'h0C, 8'h00, 8'h01, 8'h01, 8'h03, 8'h7C};
    logic [7:0] ila_mf1_l1 [8] = '{8'h1C, 8'h9C, 8'h0C, 8'h01, 8'h01, 8'h01, 8'h03, 8'h7C};
    logic [7:0] ila_oth    [8] = '{8'h1C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7C};
    logic       ila_k_mf1  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ila_k_oth  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic tick_raw(input string nm, input logic [15:0] d, input logic [1:0] k,
                            input logic vld, input logic rdy, input logic pulse,
                            input logic [1:0] st, input logic err);
        exp_t e;
        e.name  = nm;
        e.data  = d;
        e.k     = k;
        e.vld   = vld;
        e.rdy   = rdy;
        e.pulse = pulse;
        e.err   = err;
        e.st    = st;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic tick(input string nm, input logic [15:0] d, input logic [1:0] k,
                        input logic vld, input logic [1:0] st, input logic err);
        tick_raw(nm, d, k, vld, (st == 2'd2), ((j % 8) == 0), st, err);
        j++;
    endtask

    // Monitor: one expected record per edge, compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (o_data !== e.data || o_k !== e.k || o_vld !== e.vld || o_ready !== e.rdy ||
                    o_lmfc_pulse !== e.pulse || o_state !== e.st || o_sync_err !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: got data=%h k=%b vld=%b rdy=%b lmfc=%b st=%0d err=%b, want data=%h k=%b vld=%b rdy=%b lmfc=%b st=%0d err=%b",
                             e.name, o_data, o_k, o_vld, o_ready, o_lmfc_pulse, o_state, o_sync_err,
                             e.data, e.k, e.vld, e.rdy, e.pulse, e.st, e.err);
                end
            end
        end
    end

    initial begin
        logic [7:0] l0, l1;
        logic       k0, k1;
        logic [3:0] tp;

        // Reset: outputs stay zero while rst is held with SYNC~ low.
        repeat (3) tick_raw("reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;

        // CGS with SYNC~ low; LMFC pulse every 8 edges.
        repeat (11) tick("cgs_hold", 16'hBCBC, 2'b11, 1'b1, 2'd0, 1'b0);

        // SYNC~ rises at lmfc_cnt=3; user inputs are ignored outside DATA.
        i_sync_n = 1'b1;
        i_data   = 16'hFFFF;
        i_k      = 2'b11;
        i_vld    = 1'b1;
        repeat (5) tick("cgs_exit", 16'hBCBC, 2'b11, 1'b1, 2'd0, 1'b0);

        // ILAS: four multiframes, multiframe 1 carries the config octets.
        for (int m = 0; m < 4; m++) begin
            for (int o = 0; o < 8; o++) begin
                if (m == 1) begin
                    l0 = ila_mf1_l0[o];
                    l1 = ila_mf1_l1[o];
                    k0 = ila_k_mf1[o];
                end else begin
                    l0 = ila_oth[o];
                    l1 = ila_oth[o];
                    k0 = ila_k_oth[o];
                end
                k1 = k0;
                tick((m == 1) ? "ila_mf1" : "ila_mf", {l1, l0}, {k1, k0}, 1'b1, 2'd1, 1'b0);
            end
        end

        // DATA: user octets pass through with one cycle latency.
        i_data = 16'hA55A; i_k = 2'b00; i_vld = 1'b1;
        tick("data_first", 16'hA55A, 2'b00, 1'b1, 2'd2, 1'b0);
        i_data = 16'h1234; i_k = 2'b01;
        tick("data_k", 16'h1234, 2'b01, 1'b1, 2'd2, 1'b0);
        i_data = 16'hDEAD; i_k = 2'b11; i_vld = 1'b0;
        tick("idle", 16'h0000, 2'b00, 1'b0, 2'd2, 1'b0);
        i_data = 16'h00FF; i_k = 2'b10; i_vld = 1'b1;
        tick("data_after_idle", 16'h00FF, 2'b10, 1'b1, 2'd2, 1'b0);

`ifdef TX_LINK_TEST_PATTERN_EN
        // Test pattern counter started at 0 on the first DATA output (j=48).
        i_test_en = 1'b1; i_vld = 1'b0; i_data = 16'hDEAD;
        for (int n = 0; n < 17; n++) begin
            tp = 4'(j - 48);
            tick("test_pat", {4'h1, tp, 4'h0, tp}, 2'b00, 1'b1, 2'd2, 1'b0);
        end
        i_test_en = 1'b0;
`endif

        // Short SYNC~ glitch: one error pulse, DATA holds.
        i_data = 16'h5AA5; i_k = 2'b00; i_vld = 1'b1;
        i_sync_n = 1'b0;
        repeat (3) tick("glitch_low", 16'h5AA5, 2'b00, 1'b1, 2'd2, 1'b0);
        i_sync_n = 1'b1;
        tick("glitch_err", 16'h5AA5, 2'b00, 1'b1, 2'd2, 1'b1);
        tick("glitch_clear", 16'h5AA5, 2'b00, 1'b1, 2'd2, 1'b0);

        // Four low cycles: state goes to CGS, K28.5 follows one cycle later.
        i_sync_n = 1'b0;
        repeat (4) tick("resync_low", 16'h5AA5, 2'b00, 1'b1, 2'd2, 1'b0);
        repeat (4) tick("resync_cgs", 16'hBCBC, 2'b11, 1'b1, 2'd0, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending records, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
